ddr_burst_sched: RTL and testbench

- Burst scheduler for the single 256-bit DDR stream port shared by the write path (RNG/alpha data to DDR) and the read-back path (delayed data from DDR).
- Arms on sr_start_write_ddr_i and starts on the next PPS edge, loading the dq_gc start value.
- Tracks DDR fill level and grants fixed-length write or read bursts against the delay and full thresholds.
- Drains DDR cleanly when stopped.
- Sits between the AXIL register bank and the ddr_data stream FIFOs, in the clk200 domain.

---
 rtl/ddr_sched_pkg.sv | 20 ++
 rtl/ddr_sched_arb.sv | 60 ++++++
 rtl/ddr_burst_sched.sv | 144 ++++++++++++++
 tb/tb_ddr_burst_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sched_pkg.sv
// Shared encodings for the DDR burst scheduler: FSM states, grant types and
// the global counter width.
package ddr_sched_pkg;

  localparam int GC_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GT_NONE = 2'd0,
    GT_WR   = 2'd1,
    GT_RD   = 2'd2
  } gtype_t;

endpackage

// File: rtl/ddr_sched_arb.sv
// Burst arbiter: decides which burst type (and length) to grant in a free slot.
// Combinational decision; only the last-granted type is registered.
module ddr_sched_arb
  import ddr_sched_pkg::*;
#(
  parameter int BURST_LEN   = 16,
  parameter int DEPTH_BEATS = 1048576,
  parameter int LVL_W       = 32,
  parameter int LEN_W       = $clog2(BURST_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  state_t           state,
  input  logic             slot,
  input  logic [LVL_W-1:0] level,
  input  logic [LVL_W-1:0] thr,
  input  logic [LVL_W-1:0] thr_full,
  input  logic [15:0]      wr_fifo_level,
  input  logic [15:0]      rd_fifo_space,
  output gtype_t           pick,
  output logic [LEN_W-1:0] len
);

  localparam logic [15:0]      BL_16   = 16'(BURST_LEN);
  localparam logic [LVL_W-1:0] BL_LVL  = LVL_W'(BURST_LEN);
  localparam logic [LVL_W:0]   DEPTH_X = (LVL_W+1)'(DEPTH_BEATS);
  localparam logic [LEN_W-1:0] BL_LEN  = LEN_W'(BURST_LEN);

  gtype_t last_q;
  logic   wr_ok, space_ok, rd_full, rd_short, rd_ok, rd_pri;

  assign wr_ok    = (state == ST_RUN) && (wr_fifo_level >= BL_16) &&
                    (({1'b0, level} + {1'b0, BL_LVL}) <= DEPTH_X);
  assign space_ok = (rd_fifo_space >= BL_16);
  assign rd_full  = space_ok && (level >= BL_LVL) &&
                    ((state == ST_DRAIN) || ((state == ST_RUN) && (level >= thr)));
  // While draining, a remainder smaller than one burst goes out as a short burst.
  assign rd_short = space_ok && (state == ST_DRAIN) && (level != '0) && (level < BL_LVL);
  assign rd_ok    = rd_full || rd_short;
  assign rd_pri   = (level >= thr_full);

  always_comb begin
    pick = GT_NONE;
    len  = BL_LEN;
    if (slot) begin
      if (rd_ok && (rd_pri || !wr_ok || (last_q == GT_WR))) begin
        pick = GT_RD;
        if (rd_short) len = level[LEN_W-1:0];
      end else if (wr_ok) begin
        pick = GT_WR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last_q <= GT_RD;
    else if (pick != GT_NONE)  last_q <= pick;
  end

endmodule

// File: rtl/ddr_burst_sched.sv
// Burst scheduler for the shared DDR stream port: PPS-armed run control, global
// counter, DDR fill level and fixed-length write/read burst grants.
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int BURST_LEN   = 16,
  parameter int DEPTH_BEATS = 1048576,
  parameter int LVL_W       = 32
) (
  input  logic             clk200_i,
  input  logic             ddr_data_rstn,
  input  logic             pps_i,
  input  logic             sr_start_write_ddr_i,
  input  logic [GC_W-1:0]  sr_dq_gc_start_i,
  input  logic [LVL_W-1:0] sr_threshold_i,
  input  logic [LVL_W-1:0] sr_threshold_full_i,
  input  logic [15:0]      wr_fifo_level_i,
  input  logic [15:0]      rd_fifo_space_i,
  input  logic             wr_beat_i,
  input  logic             rd_beat_i,
  output logic             wr_grant_o,
  output logic             rd_grant_o,
  output logic             running_o,
  output logic [GC_W-1:0]  sr_current_dq_gc,
  output logic [LVL_W-1:0] ddr_level_o,
  output logic             overflow_o,
  output logic             proto_err_o,
  output logic [1:0]       state_o
);

  localparam int LEN_W = $clog2(BURST_LEN) + 1;
  localparam logic [15:0]      BL_16   = 16'(BURST_LEN);
  localparam logic [LVL_W:0]   BL_X    = (LVL_W+1)'(BURST_LEN);
  localparam logic [LVL_W:0]   DEPTH_X = (LVL_W+1)'(DEPTH_BEATS);

  state_t           state_q, state_d;
  logic             pps_q, pps_rise, grant_act, burst_beat, arm, stray, ov_hit;
  logic [GC_W-1:0]  gc_q;
  logic [LVL_W-1:0] level_q;
  logic [LEN_W-1:0] burst_len_q, beat_cnt_q, pick_len;
  gtype_t           pick;

  assign pps_rise   = pps_i & ~pps_q;
  assign grant_act  = wr_grant_o | rd_grant_o;
  assign burst_beat = (wr_grant_o & wr_beat_i) | (rd_grant_o & rd_beat_i);
  assign arm        = (state_q == ST_IDLE) & sr_start_write_ddr_i;
  assign stray      = (wr_beat_i & ~wr_grant_o) | (rd_beat_i & ~rd_grant_o) |
                      (rd_beat_i & ~wr_beat_i & (level_q == '0));
  assign ov_hit     = (state_q == ST_RUN) && (wr_fifo_level_i >= BL_16) &&
                      (({1'b0, level_q} + BL_X) > DEPTH_X);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (sr_start_write_ddr_i) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!sr_start_write_ddr_i) state_d = ST_IDLE;
        else if (pps_rise)         state_d = ST_RUN;
      end
      ST_RUN:   if (!sr_start_write_ddr_i) state_d = ST_DRAIN;
      ST_DRAIN: if ((level_q == '0) && !grant_act) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // pps_q resets high so a PPS already high when reset lifts is not an edge.
  always_ff @(posedge clk200_i or negedge ddr_data_rstn) begin
    if (!ddr_data_rstn) begin
      state_q <= ST_IDLE;
      pps_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pps_q   <= pps_i;
    end
  end

  always_ff @(posedge clk200_i or negedge ddr_data_rstn) begin
    if (!ddr_data_rstn)                                 gc_q <= '0;
    else if ((state_q == ST_ARMED) && (state_d == ST_RUN)) gc_q <= sr_dq_gc_start_i;
    else if (running_o)                                 gc_q <= gc_q + GC_W'(1);
  end

  always_ff @(posedge clk200_i or negedge ddr_data_rstn) begin
    if (!ddr_data_rstn) begin
      level_q     <= '0;
      overflow_o  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      if (wr_beat_i && !rd_beat_i)
        level_q <= level_q + LVL_W'(1);
      else if (rd_beat_i && !wr_beat_i && (level_q != '0))
        level_q <= level_q - LVL_W'(1);
      overflow_o  <= (overflow_o & ~arm) | ov_hit;
      proto_err_o <= (proto_err_o & ~arm) | stray;
    end
  end

  // A new burst is only decided while no grant is held, which leaves one idle
  // cycle between consecutive bursts.
  always_ff @(posedge clk200_i or negedge ddr_data_rstn) begin
    if (!ddr_data_rstn) begin
      wr_grant_o  <= 1'b0;
      rd_grant_o  <= 1'b0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
    end else if (!grant_act) begin
      wr_grant_o  <= (pick == GT_WR);
      rd_grant_o  <= (pick == GT_RD);
      burst_len_q <= pick_len;
      beat_cnt_q  <= '0;
    end else if (burst_beat) begin
      if ((beat_cnt_q + LEN_W'(1)) == burst_len_q) begin
        wr_grant_o <= 1'b0;
        rd_grant_o <= 1'b0;
      end
      beat_cnt_q <= beat_cnt_q + LEN_W'(1);
    end
  end

  ddr_sched_arb #(
    .BURST_LEN  (BURST_LEN),
    .DEPTH_BEATS(DEPTH_BEATS),
    .LVL_W      (LVL_W),
    .LEN_W      (LEN_W)
  ) u_arb (
    .clk          (clk200_i),
    .rst_n        (ddr_data_rstn),
    .state        (state_q),
    .slot         (~grant_act),
    .level        (level_q),
    .thr          (sr_threshold_i),
    .thr_full     (sr_threshold_full_i),
    .wr_fifo_level(wr_fifo_level_i),
    .rd_fifo_space(rd_fifo_space_i),
    .pick         (pick),
    .len          (pick_len)
  );

  assign running_o        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign state_o          = state_q;
  assign sr_current_dq_gc = gc_q;
  assign ddr_level_o      = level_q;

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Bench for ddr_burst_sched: directed scenarios plus randomized episodes, all
// outputs compared every cycle against a transaction-level model.
module tb_ddr_burst_sched;

  localparam int BL    = 16;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n, pps, start, wr_beat, rd_beat;
  logic [47:0] gc_start;
  logic [31:0] thr, thr_full;
  logic [15:0] wr_lvl, rd_sp;
  logic        wr_grant_o, rd_grant_o, running_o, overflow_o, proto_err_o;
  logic [47:0] sr_current_dq_gc;
  logic [31:0] ddr_level_o;
  logic [1:0]  state_o;

  int checks = 0, errors = 0, nprint = 0;
  bit chk_en = 0, auto_en = 0, stray_en = 0, trk = 0;
  int acc = 100;
  int gq[$];
  longint lmin, lmax;
  logic prev_wr = 1'b0, prev_rd = 1'b0;

  always #5 clk = ~clk;

  ddr_burst_sched #(.BURST_LEN(BL), .DEPTH_BEATS(DEPTH), .LVL_W(32)) dut (
    .clk200_i(clk), .ddr_data_rstn(rst_n), .pps_i(pps), .sr_start_write_ddr_i(start),
    .sr_dq_gc_start_i(gc_start), .sr_threshold_i(thr), .sr_threshold_full_i(thr_full),
    .wr_fifo_level_i(wr_lvl), .rd_fifo_space_i(rd_sp), .wr_beat_i(wr_beat), .rd_beat_i(rd_beat),
    .wr_grant_o(wr_grant_o), .rd_grant_o(rd_grant_o), .running_o(running_o),
    .sr_current_dq_gc(sr_current_dq_gc), .ddr_level_o(ddr_level_o),
    .overflow_o(overflow_o), .proto_err_o(proto_err_o), .state_o(state_o));

  // Model: st 0..3 = IDLE/ARMED/RUN/DRAIN; bt = burst in flight (0 none, 1 wr, 2 rd)
  typedef struct packed {
    logic [1:0]  st;
    logic [47:0] gc;
    logic [31:0] lvl;
    logic [1:0]  bt;
    logic [8:0]  left;
    logic [1:0]  last;
    logic        ov, err, ppsq;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t rst_m();
    mdl_t r;
    r = '0;
    r.last = 2'd2;
    r.ppsq = 1'b1;
    return r;
  endfunction

  function automatic mdl_t next_m(mdl_t c);
    mdl_t   n;
    longint lvl, rd_n;
    bit     rise, act, wr_ok;
    n = c;
    lvl  = longint'(c.lvl);
    rise = pps && !c.ppsq;
    act  = (c.st == 2'd2) || (c.st == 2'd3);
    n.ppsq = pps;
    case (c.st)
      2'd0: if (start) n.st = 2'd1;
      2'd1: if (!start) n.st = 2'd0; else if (rise) n.st = 2'd2;
      2'd2: if (!start) n.st = 2'd3;
      default: if (lvl == 0 && c.bt == 2'd0) n.st = 2'd0;
    endcase
    if (c.st == 2'd1 && n.st == 2'd2) n.gc = gc_start;
    else if (act) n.gc = c.gc + 48'd1;
    if (c.bt == 2'd0 && act) begin
      wr_ok = (c.st == 2'd2) && (int'(wr_lvl) >= BL) && (lvl + BL <= DEPTH);
      rd_n = 0;
      if (int'(rd_sp) >= BL) begin
        if (c.st == 2'd3) rd_n = (lvl >= BL) ? BL : lvl;
        else if (lvl >= BL && lvl >= longint'(thr)) rd_n = BL;
      end
      if (rd_n > 0 && (lvl >= longint'(thr_full) || !wr_ok || c.last == 2'd1)) begin
        n.bt = 2'd2; n.left = 9'(rd_n); n.last = 2'd2;
      end else if (wr_ok) begin
        n.bt = 2'd1; n.left = 9'(BL); n.last = 2'd1;
      end
    end else if ((c.bt == 2'd1 && wr_beat) || (c.bt == 2'd2 && rd_beat)) begin
      n.left = c.left - 9'd1;
      if (n.left == 9'd0) n.bt = 2'd0;
    end
    if (wr_beat && !rd_beat) n.lvl = c.lvl + 32'd1;
    else if (rd_beat && !wr_beat && lvl != 0) n.lvl = c.lvl - 32'd1;
    if (c.st == 2'd0 && start) begin n.err = 1'b0; n.ov = 1'b0; end
    if ((wr_beat && c.bt != 2'd1) || (rd_beat && c.bt != 2'd2) || (rd_beat && !wr_beat && lvl == 0))
      n.err = 1'b1;
    if (c.st == 2'd2 && int'(wr_lvl) >= BL && lvl + BL > DEPTH) n.ov = 1'b1;
    return n;
  endfunction

  initial begin
    m = rst_m();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m = rst_m();
      else        m = next_m(m);
    end
  end

  initial begin : compare
    logic [86:0] got, exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        got = {wr_grant_o, rd_grant_o, running_o, overflow_o, proto_err_o, state_o, ddr_level_o, sr_current_dq_gc};
        exp = {m.bt == 2'd1, m.bt == 2'd2, (m.st == 2'd2 || m.st == 2'd3), m.ov, m.err, m.st, m.lvl, m.gc};
        checks++;
        if (got !== exp) begin
          errors++;
          if (nprint < 20) $display("FAIL cycle_compare t=%0t got %h expected %h", $time, got, exp);
          nprint++;
        end
      end
      if (wr_grant_o && !prev_wr) gq.push_back(1);
      if (rd_grant_o && !prev_rd) gq.push_back(2);
      prev_wr = wr_grant_o;
      prev_rd = rd_grant_o;
      if (trk) begin
        if (longint'(ddr_level_o) < lmin) lmin = longint'(ddr_level_o);
        if (longint'(ddr_level_o) > lmax) lmax = longint'(ddr_level_o);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    int r;
    @(posedge clk);
    #1;
    if (auto_en) begin
      wr_beat = wr_grant_o && ($urandom_range(99) < acc);
      rd_beat = rd_grant_o && ($urandom_range(99) < acc);
    end
    if (stray_en) begin
      r = $urandom_range(999);
      if (r == 0) wr_beat = 1'b1;
      if (r == 1) rd_beat = 1'b1;
    end
  endtask

  task automatic track_reset();
    lmin = 64'h7fff_ffff;
    lmax = 0;
    trk  = 1;
  endtask

  initial begin : main
    int n_same, n_rd;
    rst_n = 0; pps = 0; start = 0; gc_start = '0; thr = '0; thr_full = '1;
    wr_lvl = '0; rd_sp = '0; wr_beat = 0; rd_beat = 0;
    step();
    chk_en = 1;
    repeat (2) step();
    chk("rst_state", longint'(state_o), 0);
    chk("rst_level", longint'(ddr_level_o), 0);
    chk("rst_gc", longint'(sr_current_dq_gc), 0);
    chk("rst_flags", longint'({wr_grant_o, rd_grant_o, running_o, overflow_o, proto_err_o}), 0);
    rst_n = 1;
    step();

    // Arm, then PPS 1000 cycles later loads the gc start value.
    gc_start = 48'h433; thr = 64; thr_full = 200; wr_lvl = 100; rd_sp = 100;
    acc = 100; auto_en = 1; start = 1;
    repeat (1000) step();
    chk("armed_gap", longint'(state_o), 1);
    pps = 1; gq.delete();
    step();
    chk("run_on_pps", longint'(state_o), 2);
    chk("gc_loaded", longint'(sr_current_dq_gc), 48'h433);
    repeat (10) step();
    chk("gc_plus10", longint'(sr_current_dq_gc), 48'h43D);
    pps = 0;

    // Writes alone until the read threshold, then alternation.
    for (int i = 0; i < 500 && !rd_grant_o; i++) step();
    chk("first_read_level", longint'(ddr_level_o), 64);
    chk("writes_before_read", gq.size(), 4);
    n_rd = 0;
    foreach (gq[i]) if (gq[i] == 2) n_rd++;
    chk("no_read_before", n_rd, 0);
    gq.delete(); track_reset();
    repeat (300) step();
    trk = 0;
    chk("alt_min", lmin, 48);
    chk("alt_max", lmax, 64);
    n_same = 0;
    for (int i = 0; i + 1 < gq.size(); i++) if (gq[i] == gq[i+1]) n_same++;
    chk("alt_repeats", n_same, 0);
    chk("alt_bursts", gq.size() >= 8, 1);

    // Full threshold: reads blocked up to 96, then they take consecutive slots.
    rd_sp = 0; thr_full = 80;
    for (int i = 0; i < 400 && !(ddr_level_o == 96 && !wr_grant_o && !rd_grant_o); i++) step();
    chk("reach_96", longint'(ddr_level_o), 96);
    rd_sp = 200; gq.delete();
    repeat (60) step();
    chk("prio_seq", (gq.size() >= 3) ? longint'(gq[0] * 100 + gq[1] * 10 + gq[2]) : -1, 221);
    thr_full = 200;

    // Overflow: reads blocked, writes pending.
    rd_sp = 0;
    for (int i = 0; i < 600 && ddr_level_o != DEPTH; i++) step();
    repeat (40) step();
    chk("ovf_level", longint'(ddr_level_o), DEPTH);
    chk("ovf_set", longint'(overflow_o), 1);
    wr_lvl = 0; rd_sp = 100;
    repeat (100) step();
    chk("ovf_level_dropped", longint'(ddr_level_o < DEPTH), 1);
    chk("ovf_sticky", longint'(overflow_o), 1);

    // Stop mid write burst: burst completes, then the region drains to empty.
    thr = 0;
    for (int i = 0; i < 600 && !(ddr_level_o == 0 && !wr_grant_o && !rd_grant_o); i++) step();
    rd_sp = 0; wr_lvl = 100;
    for (int i = 0; i < 300 && ddr_level_o != 40; i++) step();
    chk("stop_at_40", longint'(ddr_level_o), 40);
    start = 0; rd_sp = 100; gq.delete(); track_reset();
    for (int i = 0; i < 400 && state_o != 0; i++) step();
    trk = 0;
    chk("drain_idle", longint'(state_o), 0);
    chk("drain_peak", lmax, 48);
    chk("drain_reads", gq.size(), 3);
    n_rd = 0;
    foreach (gq[i]) if (gq[i] == 2) n_rd++;
    chk("drain_all_reads", n_rd, 3);
    chk("drain_level", longint'(ddr_level_o), 0);
    chk("drain_running", longint'(running_o), 0);

    // Restart clears sticky flags; reset lands in the middle of a read burst.
    start = 1; step(); pps = 1; step(); pps = 0;
    chk("rerun_state", longint'(state_o), 2);
    chk("ovf_cleared_on_arm", longint'(overflow_o), 0);
    wr_lvl = 100; rd_sp = 0;
    for (int i = 0; i < 200 && !(ddr_level_o == 32 && !wr_grant_o && !rd_grant_o); i++) step();
    wr_lvl = 0; rd_sp = 100;
    for (int i = 0; i < 100 && !rd_grant_o; i++) step();
    chk("rd_before_reset", longint'(rd_grant_o), 1);
    repeat (4) step();
    rst_n = 0;
    #1;
    chk("mid_rst_flags", longint'({wr_grant_o, rd_grant_o, running_o, overflow_o, proto_err_o}), 0);
    chk("mid_rst_level", longint'(ddr_level_o), 0);
    chk("mid_rst_state", longint'(state_o), 0);
    chk("mid_rst_gc", longint'(sr_current_dq_gc), 0);
    step();
    rst_n = 1;
    start = 1; step(); pps = 1; step(); pps = 0;
    auto_en = 0; wr_beat = 0; rd_beat = 0;
    step();
    rd_beat = 1; step(); rd_beat = 0; step();
    chk("stray_rd_err", longint'(proto_err_o), 1);
    chk("stray_rd_level", longint'(ddr_level_o), 0);
    for (int i = 0; i < 5; i++) begin wr_beat = 1; step(); wr_beat = 0; step(); end
    chk("stray_wr_level", longint'(ddr_level_o), 5);
    auto_en = 1; gq.delete(); start = 0;
    for (int i = 0; i < 200 && state_o != 0; i++) step();
    chk("short_drain_idle", longint'(state_o), 0);
    chk("short_drain_seq", (gq.size() == 1) ? longint'(gq[0]) : -1, 2);
    chk("short_drain_level", longint'(ddr_level_o), 0);

    // Randomized episodes, including gc wrap and an aborted arm.
    for (int e = 0; e < 6; e++) begin
      gc_start = (e == 0) ? 48'hFFFF_FFFF_FFF0 : {16'($urandom), $urandom};
      thr = $urandom_range(100); thr_full = $urandom_range(140, 40);
      stray_en = 1; start = 1;
      repeat ($urandom_range(20, 1)) step();
      if (e == 2) begin start = 0; step(); step(); start = 1; step(); end
      pps = 1; step(); pps = 0;
      for (int k = 0; k < 8; k++) begin
        wr_lvl = 16'($urandom_range(40)); rd_sp = 16'($urandom_range(40));
        acc = $urandom_range(100, 30); thr = $urandom_range(100);
        repeat (40) step();
      end
      stray_en = 0; start = 0; rd_sp = 100;
      for (int i = 0; i < 3000 && state_o != 0; i++) step();
      chk("episode_drained", longint'(state_o), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
